// File: rtl/credit_packet_injector.sv
// Credit-based packet injector: serialises packet descriptors into head/body/tail
// flits on one injection channel, sending only while the packet's VC holds credit.
module credit_packet_injector #(
  parameter int NUM_VCS            = 4,
  parameter int VC_IDX_WIDTH       = 2,
  parameter int BUFFER_SIZE        = 8,
  parameter int ROUTER_ADDR_WIDTH  = 4,
  parameter int MAX_PAYLOAD_LENGTH = 4,
  parameter int FLIT_DATA_WIDTH    = 64,
  localparam int LEN_WIDTH         = $clog2(MAX_PAYLOAD_LENGTH + 1),
  localparam int CNT_WIDTH         = $clog2(BUFFER_SIZE + 1),
  localparam int CHANNEL_WIDTH     = 1 + VC_IDX_WIDTH + 2 + FLIT_DATA_WIDTH,
  localparam int FLOW_CTRL_WIDTH   = 1 + VC_IDX_WIDTH
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          pkt_valid,
  output logic                          pkt_ready,
  input  logic [VC_IDX_WIDTH-1:0]       pkt_vc,
  input  logic [ROUTER_ADDR_WIDTH-1:0]  pkt_dest,
  input  logic [LEN_WIDTH-1:0]          pkt_length,
  output logic [0:CHANNEL_WIDTH-1]      channel_out,
  input  logic [0:FLOW_CTRL_WIDTH-1]    flow_ctrl_in,
  output logic                          busy,
  output logic                          credit_error,
  output logic [31:0]                   flit_count
);

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_SEND = 1'b1
  } state_t;

  state_t                         r_state;
  logic [VC_IDX_WIDTH-1:0]        r_vc;
  logic [ROUTER_ADDR_WIDTH-1:0]   r_dest;
  logic [LEN_WIDTH-1:0]           r_len;
  logic [LEN_WIDTH-1:0]           r_idx;
  logic [7:0]                     r_pkt_id;
  logic [0:CHANNEL_WIDTH-1]       r_channel;
  logic [31:0]                    r_flit_count;
  logic [CNT_WIDTH-1:0]           r_credit [NUM_VCS];
  logic                           r_credit_error;

  logic                           w_send;
  logic                           w_head;
  logic                           w_tail;
  logic                           w_ret_valid;
  logic [VC_IDX_WIDTH-1:0]        w_ret_vc;
  logic [LEN_WIDTH-1:0]           w_len_clamped;
  logic [FLIT_DATA_WIDTH-1:0]     w_flit_data;
  logic [NUM_VCS-1:0]             w_inc;
  logic [NUM_VCS-1:0]             w_dec;

  // Send decision looks only at the registered credit count, so a credit
  // returned this cycle can be spent from the next edge onward.
  assign w_send        = (r_state == ST_SEND) && (r_credit[r_vc] != '0);
  assign w_head        = (r_idx == '0);
  assign w_tail        = (r_idx == r_len);
  assign w_ret_valid   = flow_ctrl_in[0];
  assign w_ret_vc      = flow_ctrl_in[1:VC_IDX_WIDTH];
  assign w_len_clamped = (pkt_length > LEN_WIDTH'(MAX_PAYLOAD_LENGTH))
                       ? LEN_WIDTH'(MAX_PAYLOAD_LENGTH) : pkt_length;

  always_comb begin
    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    w_flit_data = '0;
    if (w_head) begin
      w_flit_data[ROUTER_ADDR_WIDTH-1:0]  = r_dest;
      w_flit_data[ROUTER_ADDR_WIDTH +: 8] = r_pkt_id;
    end else begin
      w_flit_data[LEN_WIDTH-1:0] = r_idx;
    end
  end

  always_comb begin
    w_inc = '0;
    w_dec = '0;
    for (int v = 0; v < NUM_VCS; v++) begin
      w_inc[v] = w_ret_valid && (w_ret_vc == VC_IDX_WIDTH'(v));
      w_dec[v] = w_send && (r_vc == VC_IDX_WIDTH'(v));
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state      <= ST_IDLE;
      r_vc         <= '0;
      r_dest       <= '0;
      r_len        <= '0;
      r_idx        <= '0;
      r_pkt_id     <= '0;
      r_channel    <= '0;
      r_flit_count <= '0;
    end else begin
      r_channel <= '0;
      case (r_state)
        ST_IDLE: begin
          if (pkt_valid) begin
            r_vc    <= pkt_vc;
            r_dest  <= pkt_dest;
            r_len   <= w_len_clamped;
            r_idx   <= '0;
            r_state <= ST_SEND;
          end
        end
        ST_SEND: begin
          if (w_send) begin
            r_channel    <= {1'b1, r_vc, w_head, w_tail, w_flit_data};
            r_idx        <= r_idx + 1'b1;
            r_flit_count <= r_flit_count + 32'd1;
            if (w_tail) begin
              r_pkt_id <= r_pkt_id + 8'd1;
              r_state  <= ST_IDLE;
            end
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  // A send and a return on the same VC in one edge cancel out; a lone return
  // to a full counter saturates and flags the upstream protocol error.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      // NOTE: the credit array is a small register file holding initial flow-control state, so it is reset like any other register.
      for (int v = 0; v < NUM_VCS; v++) begin
        r_credit[v] <= CNT_WIDTH'(BUFFER_SIZE);
      end
      r_credit_error <= 1'b0;
    end else begin
      for (int v = 0; v < NUM_VCS; v++) begin
        if (w_inc[v] && !w_dec[v]) begin
          if (r_credit[v] == CNT_WIDTH'(BUFFER_SIZE)) begin
            r_credit_error <= 1'b1;
          end else begin
            r_credit[v] <= r_credit[v] + 1'b1;
          end
        end else if (w_dec[v] && !w_inc[v]) begin
          r_credit[v] <= r_credit[v] - 1'b1;
        end
      end
    end
  end

  assign pkt_ready    = (r_state == ST_IDLE);
  assign busy         = (r_state == ST_SEND);
  assign channel_out  = r_channel;
  assign credit_error = r_credit_error;
  assign flit_count   = r_flit_count;

endmodule

// File: tb/tb_credit_packet_injector.sv
// Randomised bench for credit_packet_injector against a flit-queue reference model
// that rebuilds each packet from the descriptor and spends per-VC credit counts.
module tb_credit_packet_injector;

  localparam int NV = 4;
  localparam int VW = 2;
  localparam int BS = 8;
  localparam int AW = 4;
  localparam int ML = 4;
  localparam int DW = 64;
  localparam int LW = 3;
  localparam int CW = 1 + VW + 2 + DW;
  localparam int FW = 1 + VW;

  logic          clk;
  logic          reset;
  logic          pkt_valid;
  logic          pkt_ready;
  logic [VW-1:0] pkt_vc;
  logic [AW-1:0] pkt_dest;
  logic [LW-1:0] pkt_length;
  logic [0:CW-1] channel_out;
  logic [0:FW-1] flow_ctrl_in;
  logic          busy;
  logic          credit_error;
  logic [31:0]   flit_count;
  logic          ret_valid;
  logic [VW-1:0] ret_vc;

  assign flow_ctrl_in = {ret_valid, ret_vc};

  credit_packet_injector dut (
    .clk          (clk),
    .reset        (reset),
    .pkt_valid    (pkt_valid),
    .pkt_ready    (pkt_ready),
    .pkt_vc       (pkt_vc),
    .pkt_dest     (pkt_dest),
    .pkt_length   (pkt_length),
    .channel_out  (channel_out),
    .flow_ctrl_in (flow_ctrl_in),
    .busy         (busy),
    .credit_error (credit_error),
    .flit_count   (flit_count)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Reference model: a packet is a queue of pending flits; credits are plain integers.
  typedef struct {
    bit          head;
    bit          tail;
    logic [63:0] data;
  } flit_t;

  flit_t         m_q[$];
  int            m_vc;
  int            m_credit[NV];
  bit            m_err;
  int unsigned   m_fc;
  int            m_pkt_id;
  logic [0:CW-1] exp_ch;

  int n_total = 0;
  int n_bad   = 0;

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    m_q.delete();
    for (int v = 0; v < NV; v++) m_credit[v] = BS;
    m_err    = 1'b0;
    m_fc     = 0;
    m_pkt_id = 0;
    m_vc     = 0;
    exp_ch   = '0;
  endtask

  task automatic model_edge();
    bit    idle_before;
    bit    send;
    flit_t f;
    int    len;
    idle_before = (m_q.size() == 0);
    send        = !idle_before && (m_credit[m_vc] > 0);
    exp_ch      = '0;
    if (send) begin
      f = m_q.pop_front();
      exp_ch = {1'b1, VW'(m_vc), f.head, f.tail, f.data};
      m_fc++;
      m_credit[m_vc]--;
      if (f.tail) m_pkt_id = (m_pkt_id + 1) % 256;
    end
    if (ret_valid) begin
      m_credit[ret_vc]++;
      if (m_credit[ret_vc] > BS) begin
        m_credit[ret_vc] = BS;
        m_err = 1'b1;
      end
    end
    if (idle_before && pkt_valid) begin
      len  = (int'(pkt_length) > ML) ? ML : int'(pkt_length);
      m_vc = int'(pkt_vc);
      f.head = 1'b1;
      f.tail = (len == 0);
      f.data = 64'(pkt_dest) | (64'(m_pkt_id) << AW);
      m_q.push_back(f);
      for (int i = 1; i <= len; i++) begin
        f.head = 1'b0;
        f.tail = (i == len);
        f.data = 64'(i);
        m_q.push_back(f);
      end
    end
  endtask

  // One clock edge: predict, clock, compare, then drop one-shot inputs.
  task automatic step();
    model_edge();
    @(posedge clk);
    #1;
    check("chan",  channel_out, exp_ch);
    check("ready", pkt_ready,   m_q.size() == 0);
    check("busy",  busy,        m_q.size() != 0);
    check("err",   credit_error, m_err);
    check("count", flit_count,  m_fc);
    pkt_valid = 1'b0;
    ret_valid = 1'b0;
  endtask

  task automatic send_pkt(input int vc, input int dest, input int len);
    pkt_valid  = 1'b1;
    pkt_vc     = VW'(vc);
    pkt_dest   = AW'(dest);
    pkt_length = LW'(len);
    step();
  endtask

  task automatic give_credit(input int vc);
    ret_valid = 1'b1;
    ret_vc    = VW'(vc);
  endtask

  task automatic drain(input int max_cycles);
    int n = 0;
    while (m_q.size() != 0 && n < max_cycles) begin
      step();
      n++;
    end
    step();
  endtask

  task automatic async_reset();
    reset     = 1'b0;
    pkt_valid = 1'b1;
    #2;
    check("rst_chan",  channel_out, 0);
    check("rst_ready", pkt_ready, 1);
    check("rst_busy",  busy, 0);
    check("rst_count", flit_count, 0);
    check("rst_err",   credit_error, 0);
    model_reset();
    @(posedge clk);
    #1;
    check("rst_ignore_valid", busy, 0);
    reset     = 1'b1;
    pkt_valid = 1'b0;
  endtask

  initial begin
    reset      = 1'b1;
    pkt_valid  = 1'b0;
    pkt_vc     = '0;
    pkt_dest   = '0;
    pkt_length = '0;
    ret_valid  = 1'b0;
    ret_vc     = '0;
    #1;
    async_reset();
    repeat (3) step();

    // Basic packet: vc 1, dest 5, three body flits.
    send_pkt(1, 5, 3);
    drain(20);
    check("basic_count", flit_count, 4);

    // Exhaust vc 0, then trickle credits back one at a time.
    send_pkt(0, 9, 4);
    drain(20);
    send_pkt(0, 10, 4);
    repeat (8) step();
    check("stalled_busy", busy, 1);
    repeat (6) begin
      give_credit(0);
      step();
      step();
    end
    drain(20);

    // Send and return on vc 2 in the same edge, then overflow vc 3.
    send_pkt(2, 3, 4);
    give_credit(2);
    step();
    drain(20);
    give_credit(3);
    step();
    repeat (2) step();
    check("err_sticky", credit_error, 1);

    // Zero-length packet and an over-long length that gets clamped.
    send_pkt(3, 2, 0);
    drain(10);
    send_pkt(3, 2, 7);
    drain(20);

    // Reset mid-packet after two flits, then a fresh packet restarts pkt_id.
    send_pkt(2, 6, 4);
    step();
    step();
    async_reset();
    send_pkt(0, 1, 2);
    drain(20);

    // Random traffic with credits only returned to VCs that have some outstanding.
    for (int c = 0; c < 1500; c++) begin
      int rv;
      pkt_valid  = ($urandom_range(0, 3) == 0);
      pkt_vc     = VW'($urandom_range(0, NV - 1));
      pkt_dest   = AW'($urandom);
      pkt_length = LW'($urandom_range(0, 7));
      rv = $urandom_range(0, NV - 1);
      if ($urandom_range(0, 2) == 0 && m_credit[rv] < BS) give_credit(rv);
      step();
    end

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule

// File: doc/credit_packet_injector.md
# credit_packet_injector

Per-node traffic injector feeding one injection port of the router network: accepts packet descriptors, serialises each into head/body/tail flits, and drives one injection channel. Tracks per-VC credits returned on the matching injection flow-control vector, so no flit is sent without downstream buffer space. One instance per router, placed directly upstream of the network's injection port.

## Interface
- num_vcs, 4, number of VCs on the injection port.
- vc_idx_width, 2, clogb(num_vcs).
- buffer_size, 8, downstream input buffer depth per VC; initial credit count.
- router_addr_width, 4, destination address width.
- max_payload_length, 4, maximum body flits per packet.
- flit_data_width, 64, flit payload width; must be >= router_addr_width + 8.
- Derived: len_width = clogb(max_payload_length+1); cnt_width = clogb(buffer_size+1); channel_width = 1 + vc_idx_width + 2 + flit_data_width; flow_ctrl_width = 1 + vc_idx_width.

Ports:
- clk  in  1  clock; all state on rising edge.
- reset  in  1  asynchronous, active-low reset.
- pkt_valid  in  1  descriptor valid.
- pkt_ready  out  1  descriptor accept; equals (state == IDLE).
- pkt_vc  in  vc_idx_width  VC for whole packet; must be < num_vcs.
- pkt_dest  in  router_addr_width  destination router address.
- pkt_length  in  len_width  body flit count, 0..max_payload_length.
- channel_out  out  channel_width  bit 0 valid, then vc, head, tail, then data (MSB-first [0:N-1]).
- flow_ctrl_in  in  flow_ctrl_width  bit 0 credit valid, then credit vc index.
- busy  out  1  high when state == SEND.
- credit_error  out  1  sticky: credit returned to a VC already at buffer_size.
- flit_count  out  32  total flits sent, wraps at 2^32.

## Operation
- States: IDLE, SEND. Reset -> IDLE.
- IDLE: pkt_ready=1. On edge with pkt_valid: latch vc, dest, length (values > max_payload_length clamped to max_payload_length), clear flit index, go SEND.
- SEND: on each edge where credit[vc] > 0, register one flit to channel_out, decrement credit[vc], increment flit index and flit_count. Otherwise register all-zero channel_out (bubble).
- Flit 0: head=1; data low router_addr_width bits = dest, next 8 bits = pkt_id, rest 0. Flit i (1..length): head=0, data = i zero-extended. Tail=1 on flit index == length (length 0 => single flit with head=tail=1).
- After tail edge: state -> IDLE, pkt_id increments (8-bit wrap).
- One packet in flight at a time; no VC interleaving.
- Credits: per-VC counter cnt_width bits, reset to buffer_size. Credit valid on flow_ctrl_in increments credit[credit vc]. Same edge send and return on same VC: net unchanged. Return to VC at buffer_size: counter saturates, credit_error set until reset.
- Credit-availability decision uses registered count only; credit returned in a cycle enables sending from the next edge.
- pkt_vc >= num_vcs is a protocol violation; behaviour unspecified.

## Timing
- Reset (asynchronous, active-low): channel_out=0, busy=0, credit_error=0, flit_count=0, pkt_id=0, all credits=buffer_size, state IDLE (pkt_ready=1 during reset; pkt_valid ignored while reset low).
- Reset mid-packet: packet abandoned immediately; no tail emitted.
- Acceptance edge N -> head visible on channel_out after edge N+1 with full credit.
- Full-rate: length L packet with ample credits occupies channel for L+1 consecutive cycles.
- Back-to-back packets: one idle cycle between tail and next head (IDLE acceptance cycle).
- channel_out is fully registered; flow_ctrl_in sampled only at edges; no combinational path input -> channel_out. pkt_ready combinational from state only.

## Test plan
- Reset, buffer_size=8: channel_out=0, pkt_ready=1, flit_count=0; no credit returns -> after reset release, no flits without descriptors.
- Descriptor vc=1, dest=5, length=3 at edge N, credits full -> flits at N+1..N+4: head(dest=5,pkt_id=0), data 1, 2, 3 with tail on last; credit[1]=4; flit_count=4; pkt_ready=1 after N+4.
- Credit exhaustion: buffer_size=2, length=4 on vc 0, no returns -> 2 flits then bubbles; return one credit at edge M -> next flit emitted at edge M+1, one per credit thereafter.
- Simultaneous send and return on vc 2 at same edge -> credit[2] unchanged; return on vc 3 at buffer_size -> credit_error=1, credit[3] stays 8.
- length=0 and length=7 (clamped to 4) -> single flit head=tail=1; five flits respectively; pkt_id increments 0->1.
- Async reset asserted mid-packet (after flit 2 of 5) -> channel_out=0 immediately, credits=buffer_size, state IDLE; new packet after release starts with pkt_id=0.
